// File: rtl/cpu_run_controller.sv
// Execution controller for the 4-bit core. It owns the core's reset and
// clock-enable, and it accepts HALT/RUN/STEP/RESET_CPU host commands. It also
// provides a one-entry program-address breakpoint and a saturating counter of
// executed (enabled) cycles.
module cpu_run_controller #(
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_sync_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [7:0]        i_cmd_arg,
  input  logic              i_bp_en,
  input  logic [ADDR_W-1:0] i_bp_addr,
  input  logic [ADDR_W-1:0] i_pm_address,
  output logic              o_cpu_en,
  output logic              o_cpu_reset,
  output logic [1:0]        o_run_state,
  output logic [1:0]        o_halt_cause,
  output logic              o_bp_hit,
  output logic [CNT_W-1:0]  o_cycle_count
);

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_HALTED     = 2'b01,
    ST_RUNNING    = 2'b10,
    ST_STEPPING   = 2'b11
  } state_t;

  localparam logic [1:0] OP_HALT      = 2'b00;
  localparam logic [1:0] OP_RUN       = 2'b01;
  localparam logic [1:0] OP_STEP      = 2'b10;
  localparam logic [1:0] OP_RESET_CPU = 2'b11;

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_STEP  = 2'b11;

  // The hold counter counts down to zero, so it starts one below the hold length.
  localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES - 1);

  state_t             r_state;
  logic [7:0]         r_hold;
  logic [7:0]         r_step_rem;
  logic               r_cpu_en;
  logic               r_cpu_reset;
  logic               r_cmd_ready;
  logic [1:0]         r_halt_cause;
  logic               r_bp_hit;
  logic [CNT_W-1:0]   r_cycle_count;

  logic               w_accept;
  logic               w_reset_cmd;
  logic               w_bp_match;
  state_t             w_next_state;
  logic [7:0]         w_next_hold;
  logic [7:0]         w_next_step;
  logic [1:0]         w_next_cause;
  logic               w_next_bp_hit;
  logic               w_clear_count;

  // cmd_ready is registered high in every state except RESET_HOLD. A command
  // is therefore accepted only when the controller can act on it.
  assign w_accept    = i_cmd_valid & r_cmd_ready;
  assign w_reset_cmd = w_accept & (i_cmd_op == OP_RESET_CPU);
  assign w_bp_match  = i_bp_en & (i_pm_address == i_bp_addr);

  // Next-state decision, with priority RESET_CPU > HALT > breakpoint > step done.
  always_comb begin
    w_next_state  = r_state;
    w_next_hold   = r_hold;
    w_next_step   = r_step_rem;
    w_next_cause  = r_halt_cause;
    w_next_bp_hit = 1'b0;
    w_clear_count = 1'b0;
    if (r_state != ST_RESET_HOLD && w_reset_cmd) begin
      w_next_state  = ST_RESET_HOLD;
      w_next_hold   = HOLD_INIT;
      w_next_cause  = CAUSE_RESET;
      w_clear_count = 1'b1;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_hold == 8'd0) w_next_state = ST_HALTED;
          else                w_next_hold  = r_hold - 8'd1;
        end
        ST_HALTED: begin
          if (w_accept && i_cmd_op == OP_RUN) begin
            w_next_state = ST_RUNNING;
          end else if (w_accept && i_cmd_op == OP_STEP) begin
            w_next_state = ST_STEPPING;
            w_next_step  = (i_cmd_arg == 8'd0) ? 8'd1 : i_cmd_arg;
          end
        end
        default: begin
          // RUNNING or STEPPING: the current cycle is an executed one.
          if (w_accept && i_cmd_op == OP_HALT) begin
            w_next_state = ST_HALTED;
            w_next_cause = CAUSE_HALT;
          end else if (w_bp_match) begin
            w_next_state  = ST_HALTED;
            w_next_cause  = CAUSE_BP;
            w_next_bp_hit = 1'b1;
          end else if (r_state == ST_STEPPING) begin
            if (r_step_rem == 8'd1) begin
              w_next_state = ST_HALTED;
              w_next_cause = CAUSE_STEP;
            end else begin
              w_next_step = r_step_rem - 8'd1;
            end
          end
        end
      endcase
    end
  end

  // State register, with the core controls registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_state       <= ST_RESET_HOLD;
      r_hold        <= HOLD_INIT;
      r_step_rem    <= 8'd0;
      r_cpu_en      <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_cmd_ready   <= 1'b0;
      r_halt_cause  <= CAUSE_RESET;
      r_bp_hit      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_hold       <= w_next_hold;
      r_step_rem   <= w_next_step;
      r_halt_cause <= w_next_cause;
      r_bp_hit     <= w_next_bp_hit;
      r_cpu_en     <= (w_next_state == ST_RUNNING) || (w_next_state == ST_STEPPING);
      r_cpu_reset  <= (w_next_state == ST_RESET_HOLD);
      r_cmd_ready  <= (w_next_state != ST_RESET_HOLD);
      if (w_clear_count)
        r_cycle_count <= '0;
      else if (r_cpu_en && !(&r_cycle_count))
        r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_cpu_en      = r_cpu_en;
  assign o_cpu_reset   = r_cpu_reset;
  assign o_run_state   = r_state;
  assign o_halt_cause  = r_halt_cause;
  assign o_bp_hit      = r_bp_hit;
  assign o_cycle_count = r_cycle_count;

endmodule
